fifo_drain: RTL

//  - Read-side controller for a flagless FIFO with 1-cycle read latency
//    (rd_data valid the cycle after rd_en, zero otherwise).
//  - Tracks words committed by the writer, issues rd_en, absorbs the read

---
 rtl/fifo_drain_if.sv | 22 ++
 rtl/fifo_drain.sv | 52 +++++
 2 files changed

// File: rtl/fifo_drain_if.sv
// fifo_drain_if: FIFO read port, output stream and level of fifo_drain.
// ovf exists only when FIFO_DRAIN_OVF_DET_EN is defined.
interface fifo_drain_if #(
  parameter int BIT_WIDTH = 8,
  parameter int FIFO_SIZE = 1024
);
  logic push;
  logic rd_en;
  logic [BIT_WIDTH-1:0] rd_data;
  logic out_valid;
  logic out_ready;
  logic [BIT_WIDTH-1:0] out_data;
  logic [$clog2(FIFO_SIZE+1)-1:0] level;
`ifdef FIFO_DRAIN_OVF_DET_EN
  logic ovf;
  modport master (output push, rd_data, out_ready, input rd_en, out_valid, out_data, level, ovf);
  modport slave (input push, rd_data, out_ready, output rd_en, out_valid, out_data, level, ovf);
`else
  modport master (output push, rd_data, out_ready, input rd_en, out_valid, out_data, level);
  modport slave (input push, rd_data, out_ready, output rd_en, out_valid, out_data, level);
`endif
endinterface

// File: rtl/fifo_drain.sv
// fifo_drain: read-side controller for a flagless 1-cycle-latency FIFO, 2-entry skid, valid/ready out.
// FIFO_DRAIN_OVF_DET_EN adds a sticky ovf flag for pushes into a full FIFO.
module fifo_drain #(
  parameter int BIT_WIDTH = 8,
  parameter int FIFO_SIZE = 1024
) (
  input logic clock,
  input logic n_rst,
  fifo_drain_if.slave bus
);
  localparam int LW = $clog2(FIFO_SIZE + 1);
  logic [LW-1:0] level;
  logic rd_pend, pop, full, valid;
  logic [1:0] cnt, occ, left;
  logic [BIT_WIDTH-1:0] s0, s1;
  // the word returning from the FIFO counts as queue head before it lands in the skid
  always_comb begin
    occ = cnt + {1'b0, rd_pend};
    valid = occ != 2'd0;
    pop = valid & bus.out_ready;
    left = occ - {1'b0, pop};
    full = level == LW'(FIFO_SIZE);
    bus.rd_en = n_rst & (level != '0) & (left < 2'd2);
    bus.out_valid = valid;
    bus.out_data = cnt != 2'd0 ? s0 : (rd_pend ? bus.rd_data : '0);
    bus.level = level;
  end
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      level <= '0;
      rd_pend <= 1'b0;
      cnt <= 2'd0;
      s0 <= '0;
      s1 <= '0;
    end else begin
      level <= (bus.push & ~bus.rd_en & ~full) ? level + 1'b1 :
               (~bus.push & bus.rd_en) ? level - 1'b1 : level;
      rd_pend <= bus.rd_en;
      cnt <= left;
      s0 <= pop ? (cnt == 2'd2 ? s1 : bus.rd_data) : (cnt == 2'd0 ? bus.rd_data : s0);
      s1 <= (~pop & (cnt == 2'd1)) ? bus.rd_data : s1;
    end
  end
`ifdef FIFO_DRAIN_OVF_DET_EN
  logic ovf;
  always_ff @(posedge clock) begin
    if (!n_rst) ovf <= 1'b0;
    else if (bus.push & full & ~bus.rd_en) ovf <= 1'b1;
  end
  assign bus.ovf = ovf;
`endif
endmodule
